// File: rtl/vga_layer_compositor_pkg.sv
// Shared definitions for the VGA layer compositor and its neighbours.
// Holds the default pixel format, the transparent key, VGA 640x480 timing
// constants shared with vga_controller, the flash FSM state type and a
// packed-layer slicing macro.

`define VLC_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package vga_layer_compositor_pkg;

  localparam int unsigned VGA_COLOR_W = 12;
  localparam logic [VGA_COLOR_W-1:0] VGA_TRANS_KEY = 12'hCBE;
  localparam logic [VGA_COLOR_W-1:0] VGA_BLACK = '0;

  // 640x480 @ 60 Hz timing, shared with vga_controller
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BACK = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BACK = 33;

  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic {
    StIdle,
    StFlash
  } flash_state_e;

endpackage

// File: rtl/vga_layer_compositor_layer_priority_sel.sv
// Combinational lowest-index-visible selector.
// Ports:
//   i_pixels  packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   i_vis     per-layer visibility
//   o_color   colour of the winning layer ('0 when none visible)
//   o_index   index of the winning layer
//   o_any_vis 1 when at least one layer is visible

module layer_priority_sel #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W = 12,
  localparam int unsigned IDX_W = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_pixels,
  input  logic [NUM_LAYERS-1:0]         i_vis,
  output logic [COLOR_W-1:0]            o_color,
  output logic [IDX_W-1:0]              o_index,
  output logic                          o_any_vis
);

  // Scan from the bottom up so the lowest visible index is the last to win.
  always_comb begin
    o_color   = '0;
    o_index   = '0;
    o_any_vis = 1'b0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (i_vis[i]) begin
        o_color   = `VLC_SLICE(i_pixels, i, COLOR_W);
        o_index   = IDX_W'(i);
        o_any_vis = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage pipelined VGA layer compositor. Merges NUM_LAYERS colour layers by
// index priority (layer 0 on top), with per-layer enable, frame-rate blink,
// a frame-counted flash on layer 0 and delay-matched sync/valid.
// Ports:
//   i_clk, i_rst                   pixel clock, synchronous active-high reset
//   i_vga_valid, i_hsync_in/vsync  active-video flag and active-low syncs
//   i_layer_pixels, i_layer_en,    packed layer colours, enables, blink enables
//   i_blink_en
//   i_flash_req, i_flash_color     flash start/restart pulse and flash colour
//   o_pixel, o_valid_out,          composited colour and syncs, 2 clk latency
//   o_hsync_out, o_vsync_out
//   o_flashing                     1 while the flash FSM is in FLASH

module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COLOR_W = VGA_COLOR_W,
  parameter logic [COLOR_W-1:0] TRANS_KEY = VGA_TRANS_KEY,
  parameter logic [COLOR_W-1:0] BG_COLOR = VGA_BLACK,
  parameter bit BOTTOM_OPAQUE = 1'b1,
  parameter int unsigned BLINK_BIT = 4,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_vga_valid,
  input  logic                          i_hsync_in,
  input  logic                          i_vsync_in,
  input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_pixels,
  input  logic [NUM_LAYERS-1:0]         i_layer_en,
  input  logic [NUM_LAYERS-1:0]         i_blink_en,
  input  logic                          i_flash_req,
  input  logic [COLOR_W-1:0]            i_flash_color,
  output logic [COLOR_W-1:0]            o_pixel,
  output logic                          o_valid_out,
  output logic                          o_hsync_out,
  output logic                          o_vsync_out,
  output logic                          o_flashing
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
  localparam int unsigned FCNT_W = $clog2(FLASH_FRAMES + 1);

  // Stage 1
  logic [NUM_LAYERS*COLOR_W-1:0] r_pix_s1;
  logic [NUM_LAYERS-1:0]         r_vis_s1;
  logic                          r_valid_s1;
  logic                          r_hsync_s1;
  logic                          r_vsync_s1;
  logic [NUM_LAYERS-1:0]         w_vis;

  // Stage 2
  logic [COLOR_W-1:0] r_pixel;
  logic               r_valid_s2;
  logic               r_hsync_s2;
  logic               r_vsync_s2;

  // Frame / flash state
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  flash_state_e           r_state;
  flash_state_e           w_state_nxt;
  logic [FCNT_W-1:0]      r_flash_cnt;
  logic [FCNT_W-1:0]      w_flash_cnt_nxt;
  logic                   w_frame_start;

  logic [COLOR_W-1:0] w_win_color;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any_vis;
  logic               w_flash_hit;

  // r_vsync_s1 doubles as the vsync edge register: it holds last cycle's vsync.
  assign w_frame_start = r_vsync_s1 & ~i_vsync_in;

  always_comb begin
    w_vis = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      w_vis[i] = i_layer_en[i]
               & (~i_blink_en[i] | ~r_frame_cnt[BLINK_BIT])
               & ((`VLC_SLICE(i_layer_pixels, i, COLOR_W) != TRANS_KEY)
                  | (BOTTOM_OPAQUE && (i == int'(NUM_LAYERS) - 1)));
    end
  end

  layer_priority_sel #(
    .NUM_LAYERS(NUM_LAYERS),
    .COLOR_W   (COLOR_W)
  ) u_sel (
    .i_pixels (r_pix_s1),
    .i_vis    (r_vis_s1),
    .o_color  (w_win_color),
    .o_index  (w_win_idx),
    .o_any_vis(w_any_vis)
  );

  // Flash uses the live FSM state so a mid-frame request shows on the next pixel.
  assign w_flash_hit = (r_state == StFlash) & r_flash_cnt[0] & w_any_vis & (w_win_idx == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_s1    <= '0;
      r_vis_s1    <= '0;
      r_valid_s1  <= 1'b0;
      r_hsync_s1  <= 1'b1;
      r_vsync_s1  <= 1'b1;
      r_pixel     <= '0;
      r_valid_s2  <= 1'b0;
      r_hsync_s2  <= 1'b1;
      r_vsync_s2  <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_pix_s1   <= i_layer_pixels;
      r_vis_s1   <= w_vis;
      r_valid_s1 <= i_vga_valid;
      r_hsync_s1 <= i_hsync_in;
      r_vsync_s1 <= i_vsync_in;
      r_valid_s2 <= r_valid_s1;
      r_hsync_s2 <= r_hsync_s1;
      r_vsync_s2 <= r_vsync_s1;
      if (!r_valid_s1) begin
        r_pixel <= '0;
      end else if (w_flash_hit) begin
        r_pixel <= i_flash_color;
      end else if (w_any_vis) begin
        r_pixel <= w_win_color;
      end else begin
        r_pixel <= BG_COLOR;
      end
      if (w_frame_start) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_flash_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flash_cnt_nxt = r_flash_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_flash_req) begin
          w_state_nxt     = StFlash;
          w_flash_cnt_nxt = FCNT_W'(FLASH_FRAMES);
        end
      end
      StFlash: begin
        // A request outranks a decrement landing in the same cycle.
        if (i_flash_req) begin
          w_flash_cnt_nxt = FCNT_W'(FLASH_FRAMES);
        end else if (w_frame_start) begin
          w_flash_cnt_nxt = r_flash_cnt - 1'b1;
          if (r_flash_cnt == FCNT_W'(1)) begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: begin
        w_state_nxt     = StIdle;
        w_flash_cnt_nxt = '0;
      end
    endcase
  end

  assign o_pixel     = r_pixel;
  assign o_valid_out = r_valid_s2;
  assign o_hsync_out = r_hsync_s2;
  assign o_vsync_out = r_vsync_s2;
  assign o_flashing  = (r_state == StFlash);

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Bench for vga_layer_compositor: two instances with different parameter sets
// share one stimulus stream; a frame/flash-level reference model predicts
// every output.

module tb_vga_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 12;
  localparam logic [11:0] KEY = 12'hCBE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vga_valid = 1'b0;
  logic hsync_in = 1'b1;
  logic vsync_in = 1'b1;
  logic [NL*CW-1:0] layer_pixels = '0;
  logic [NL-1:0] layer_en = '0;
  logic [NL-1:0] blink_en = '0;
  logic flash_req = 1'b0;
  logic [CW-1:0] flash_color = 12'hFFF;

  logic [CW-1:0] pix_a, pix_b;
  logic val_a, hs_a, vs_a, fl_a;
  logic val_b, hs_b, vs_b, fl_b;

  always #5 clk = ~clk;

  vga_layer_compositor dut_a (
    .i_clk(clk), .i_rst(rst), .i_vga_valid(vga_valid), .i_hsync_in(hsync_in),
    .i_vsync_in(vsync_in), .i_layer_pixels(layer_pixels), .i_layer_en(layer_en),
    .i_blink_en(blink_en), .i_flash_req(flash_req), .i_flash_color(flash_color),
    .o_pixel(pix_a), .o_valid_out(val_a), .o_hsync_out(hs_a), .o_vsync_out(vs_a),
    .o_flashing(fl_a)
  );

  vga_layer_compositor #(
    .BOTTOM_OPAQUE(1'b0),
    .BLINK_BIT(0),
    .FLASH_FRAMES(3)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_vga_valid(vga_valid), .i_hsync_in(hsync_in),
    .i_vsync_in(vsync_in), .i_layer_pixels(layer_pixels), .i_layer_en(layer_en),
    .i_blink_en(blink_en), .i_flash_req(flash_req), .i_flash_color(flash_color),
    .o_pixel(pix_b), .o_valid_out(val_b), .o_hsync_out(hs_b), .o_vsync_out(vs_b),
    .o_flashing(fl_b)
  );

  // Reference model: what each pixel looked like when captured, and how many
  // flash frames remain (0 = not flashing) for each instance.
  typedef struct {
    bit valid;
    bit hs;
    bit vs;
    logic [NL*CW-1:0] pix;
    logic [NL-1:0] en;
    logic [NL-1:0] blink;
    int fcnt;
  } snap_t;

  snap_t p1;
  int m_fcnt;
  int left_a, left_b;
  bit prev_vs;
  int total = 0;
  int bad = 0;

  function automatic logic [11:0] compose(input snap_t s, input int bb, input bit bopq,
                                          input int left, input logic [11:0] fc);
    logic [11:0] c;
    bit shown;
    if (!s.valid) return 12'h000;
    for (int i = 0; i < NL; i++) begin
      c = s.pix[i*CW +: CW];
      shown = s.en[i] && !(s.blink[i] && (((s.fcnt >> bb) & 1) == 1))
              && ((c != KEY) || (bopq && i == NL - 1));
      if (shown) return (i == 0 && (left % 2) == 1) ? fc : c;
    end
    return 12'h000;
  endfunction

  function automatic int next_left(input int left, input int frames, input bit req,
                                   input bit fs);
    if (req) return frames;
    if (fs && left > 0) return left - 1;
    return left;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [11:0] ea, eb;
    bit ev, ehs, evs, fs;
    snap_t cur;
    cur.valid = vga_valid;
    cur.hs = hsync_in;
    cur.vs = vsync_in;
    cur.pix = layer_pixels;
    cur.en = layer_en;
    cur.blink = blink_en;
    cur.fcnt = m_fcnt;
    if (rst) begin
      ea = 12'h000; eb = 12'h000; ev = 0; ehs = 1; evs = 1;
      m_fcnt = 0; left_a = 0; left_b = 0; prev_vs = 1;
      p1.valid = 0; p1.hs = 1; p1.vs = 1; p1.pix = '0; p1.en = '0; p1.blink = '0; p1.fcnt = 0;
    end else begin
      ea = compose(p1, 4, 1'b1, left_a, flash_color);
      eb = compose(p1, 0, 1'b0, left_b, flash_color);
      ev = p1.valid; ehs = p1.hs; evs = p1.vs;
      fs = prev_vs && !vsync_in;
      if (fs) m_fcnt = (m_fcnt + 1) % 256;
      left_a = next_left(left_a, 8, flash_req, fs);
      left_b = next_left(left_b, 3, flash_req, fs);
      prev_vs = vsync_in;
      p1 = cur;
    end
    @(posedge clk);
    #1;
    check("pixel_a", 32'(pix_a), 32'(ea));
    check("pixel_b", 32'(pix_b), 32'(eb));
    check("valid", 32'(val_a), 32'(ev));
    check("hsync", 32'(hs_a), 32'(ehs));
    check("vsync", 32'(vs_a), 32'(evs));
    check("vsync_b", 32'(vs_b), 32'(evs));
    check("flashing_a", 32'(fl_a), 32'(left_a > 0));
    check("flashing_b", 32'(fl_b), 32'(left_b > 0));
  endtask

  task automatic frame(input int n);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();

    // Priority: layer1 wins over key-coloured layer0
    layer_en = 4'hF;
    vga_valid = 1'b1;
    layer_pixels = {12'h00F, 12'hCBE, 12'h0F0, 12'hCBE};
    repeat (4) step();
    layer_pixels = {12'h00F, 12'hCBE, 12'hCBE, 12'hCBE};
    repeat (4) step();

    // All transparent: bottom-opaque vs background, then invalid
    layer_pixels = {4{KEY}};
    repeat (4) step();
    vga_valid = 1'b0;
    repeat (3) step();
    vga_valid = 1'b1;

    // Walking sync/valid pattern
    layer_pixels = {12'h00F, 12'h0F0, 12'h123, 12'hF00};
    for (int i = 0; i < 24; i++) begin
      hsync_in = 1'(i % 3 != 0);
      vsync_in = 1'(i % 5 != 1);
      vga_valid = 1'(i % 4 < 2);
      step();
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    vga_valid = 1'b1;

    // Blink from frame_cnt=0
    do_reset();
    layer_pixels = {12'h00F, KEY, KEY, 12'hF00};
    blink_en = 4'b0001;
    repeat (3) step();
    for (int f = 0; f < 5; f++) frame(4);
    blink_en = '0;

    // Flash with FLASH_FRAMES=3 on dut_b
    do_reset();
    flash_color = 12'hFFF;
    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    repeat (3) step();
    for (int f = 0; f < 4; f++) frame(4);
    // Layer-1-sourced pixels are never substituted
    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    layer_pixels = {12'h00F, KEY, 12'h0F0, KEY};
    repeat (3) step();
    layer_pixels = {12'h00F, KEY, KEY, 12'hF00};
    frame(3);
    frame(3);
    // Collision: request together with the frame start that would end it
    vsync_in = 1'b0;
    flash_req = 1'b1;
    step();
    vsync_in = 1'b1;
    flash_req = 1'b0;
    repeat (3) step();
    frame(3);
    // Reset mid-flash
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < NL; l++) begin
        layer_pixels[l*CW +: CW] = ($urandom_range(0, 1) == 0) ? KEY : 12'($urandom);
      end
      layer_en = 4'($urandom);
      blink_en = 4'($urandom);
      vga_valid = 1'($urandom_range(0, 3) != 0);
      hsync_in = 1'($urandom_range(0, 3) != 0);
      vsync_in = 1'($urandom_range(0, 5) != 0);
      flash_req = 1'($urandom_range(0, 24) == 0);
      flash_color = 12'($urandom);
      rst = 1'($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    flash_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed four-input VGA priority mux.
- Merges NUM_LAYERS colour layers by index priority. Layer 0 is on top. A colour equal to TRANS_KEY means transparent.
- Adds per-layer enable, per-layer frame-rate blink, a frame-counted "hit flash" effect on layer 0, and delay-matched sync/valid outputs.
- Sits between the sprite/map pixel generators and the {vgaRed, vgaGreen, vgaBlue}/hsync/vsync pins.

Parameters:
- NUM_LAYERS, 4, number of input layers (2..8); index 0 = highest priority.
- COLOR_W, 12, bits per pixel (4:4:4 RGB).
- TRANS_KEY, 12'hCBE, transparent colour key.
- BG_COLOR, 12'h000, output when no layer is opaque and BOTTOM_OPAQUE=0.
- BOTTOM_OPAQUE, 1, 1 = layer NUM_LAYERS-1 ignores the key (map layer always drawn when enabled).
- BLINK_BIT, 4, frame_cnt bit that gates blinking layers (period = 2^(BLINK_BIT+1) frames).
- FLASH_FRAMES, 8, frames a flash lasts.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- rst  in  1  synchronous, active-high reset.
- vga_valid  in  1  active-video flag from vga_controller.
- hsync_in  in  1  horizontal sync (active low).
- vsync_in  in  1  vertical sync (active low).
- layer_pixels  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i at [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  1 = layer participates (replaces display_sp-style gating).
- blink_en  in  NUM_LAYERS  1 = layer visible only while frame_cnt[BLINK_BIT]==0.
- flash_req  in  1  single-cycle pulse to start or restart the flash.
- flash_color  in  COLOR_W  colour substituted for layer-0 pixels while flashing.
- pixel  out  COLOR_W  composited colour.
- valid_out  out  1  vga_valid delayed by 2.
- hsync_out  out  1  hsync_in delayed by 2.
- vsync_out  out  1  vsync_in delayed by 2.
- flashing  out  1  1 while the FSM is in FLASH.

Behaviour:
- Reset values: pixel=0, valid_out=0, hsync_out=1, vsync_out=1, flashing=0. frame_cnt=0, FSM=IDLE, flash counter=0, vsync edge register=1.
- Latency is exactly 2 clk for pixel, valid_out, hsync_out and vsync_out. All outputs are registered.
- Stage 1 registers the following:
  - layer_pixels, vga_valid and syncs.
  - vis[i] = layer_en[i] & (~blink_en[i] | ~frame_cnt[BLINK_BIT]) & (pix[i] != TRANS_KEY). For the bottom layer with BOTTOM_OPAQUE=1, the key term is forced to 1.
- Stage 2 selection:
  - Selects the lowest i with vis[i]=1. If there is none, the result is BG_COLOR.
  - If the stage-1 valid=0, pixel = 12'h000.
  - If FSM=FLASH, flash_cnt[0]=1 and the winner is layer 0, pixel = flash_color.
- Frame start is the vsync_in falling edge (registered previous value 1, current 0). On frame start, frame_cnt (8 bit) increments and wraps 255 -> 0.
- Flash FSM, two states:
  - IDLE: flash_req -> FLASH, flash_cnt = FLASH_FRAMES.
  - FLASH, flash_req: reload flash_cnt = FLASH_FRAMES. flash_req has priority over a decrement in the same cycle.
  - FLASH, frame start: flash_cnt decrements. A frame start that takes flash_cnt from 1 to 0 returns the FSM to IDLE.
  - flashing = (state == FLASH).
- Parameter-set choice: blink and flash state change only on frame start or flash_req. Because of this, no tearing occurs mid-line except a flash_req mid-frame, which takes effect on the next pixel.
- Reset mid-frame returns all state to reset values on the next edge. Syncs are idle-high for 2 clk after release.
- layer_en/blink_en changes are sampled per pixel (stage 1). They are not synchronised to frame start.

Decomposition:
- Shared package/header (vga_defs) holds:
  - COLOR_W, TRANS_KEY and the BLACK constant.
  - The H/V timing constants shared with vga_controller.
  - A macro for packed-layer slicing.
- One sub-module, layer_priority_sel: combinational lowest-index-visible selector with a NUM_LAYERS parameter. It outputs winner colour, winner index and any_vis. It is reusable by the minimap path.

Test Plan:
- Priority: NUM_LAYERS=4, all enabled, layers = {CBE, 0F0, CBE, 00F}, valid=1 -> pixel=0F0 two clocks later. Layer1 = CBE -> pixel=00F.
- Bottom opaque / background: all layers CBE. BOTTOM_OPAQUE=1 -> pixel=CBE. With BOTTOM_OPAQUE=0 -> pixel=000 (BG_COLOR). valid=0 -> 000 in both cases.
- Latency and sync alignment: walking hsync/vsync/valid pattern -> outputs equal inputs delayed exactly 2 clk. After rst, hsync_out/vsync_out=1 and valid_out=0.
- Blink: blink_en[0]=1, layer0=F00, layer3=00F, BLINK_BIT=0 -> pixel alternates F00 / 00F on successive frames, starting F00 at frame_cnt=0.
- Flash: flash_req at frame 0, FLASH_FRAMES=3, layer0=F00, flash_color=FFF:
  - flashing=1 for 3 frame starts; pixel=FFF while flash_cnt is odd (3, 1) and F00 while even (2).
  - flashing=0 after the third frame start.
  - Layer-1-sourced pixels are never replaced.
- Restart/collision: flash_req in the same cycle as frame start during FLASH with flash_cnt=1 -> stays FLASH with flash_cnt=FLASH_FRAMES. rst asserted mid-flash -> flashing=0 next clk.
